mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  Load/store unit for the MEM stage. Sits between EX/MEM and MEM/WB.
//  - Drives a req/gnt/rvalid data-memory bus with byte enables.
//  - Aligns and sign/zero-extends load data into read_data_o, which feeds MEM/WB read_data.
//  - Raises stall_o while an access is in flight. The core freezes IF..MEM and deasserts the MEM/WB Enable.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles waited in REQ+WAIT before bus error (1..65535)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   reset, asynchronous, active-high
//  valid_m_i       in   1   MEM-stage instruction valid (not a bubble)
//  mem_read_m_i    in   1   instruction is a load
//  mem_write_m_i   in   1   instruction is a store
//  funct3_m_i      in   3   RV32I width/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU
//  addr_m_i        in   32  effective address (ALU result)
//  store_data_m_i  in   32  rs2 value for stores
//  dmem_req_o      out  1   bus request
//  dmem_we_o       out  1   1 = write
//  dmem_addr_o     out  32  word address {addr_m_i[31:2],2'b00}
//  dmem_be_o       out  4   byte enables, lane i = bits [8i+7:8i]
//  dmem_wdata_o    out  32  lane-replicated store data
//  dmem_gnt_i      in   1   request accepted this cycle
//  dmem_rvalid_i   in   1   read data valid this cycle
//  dmem_rdata_i    in   32  read data word
//  read_data_o     out  32  aligned/extended load result, registered
//  stall_o         out  1   1 = hold pipeline, MEM/WB must not capture
//  fault_o         out  1   1-cycle pulse: misaligned/illegal access or bus timeout
// BEHAVIOUR
//  Reset values: FSM=IDLE, read_data_o=0, timeout counter=0, fault_o=0.
//  Bus outputs are all 0 while rst is high (req drops immediately).
//  Access condition: acc = valid_m_i & (mem_read_m_i ^ mem_write_m_i).
//  Illegal access (acc with any of the following) -> no request, fault_o=1 for one cycle, stall_o=0, read_data_o<=0:
//   - load funct3 in {3,6,7}, or store funct3 > 2
//   - H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0
//   - valid_m_i with both mem_read_m_i and mem_write_m_i set
//  FSM states:
//  - IDLE: if legal acc -> dmem_req_o=1 (combinational), stall_o=1.
//    gnt=1 -> WAIT (load) or DONE (store); gnt=0 -> REQ.
//    No acc -> stall_o=0; rvalid ignored.
//  - REQ: req=1, stall_o=1; request fields stable (inputs frozen by stall).
//    gnt -> WAIT (load) / DONE (store).
//  - WAIT: req=0, stall_o=1. On rvalid, read_data_o<=extend(rdata) -> DONE.
//  - DONE: req=0, stall_o=0 (MEM/WB captures read_data_o); -> IDLE unconditionally.
//  Latency with zero-wait memory (gnt same cycle, rvalid next): load = 3 MEM cycles, store = 2.
//  Non-memory instructions: 0 extra cycles; read_data_o holds its last value.
//  Timeout:
//   - Counter clears on entering REQ/WAIT from IDLE and increments each cycle in REQ or WAIT.
//   - When it reaches TIMEOUT_CYCLES: fault_o pulse, read_data_o<=0, -> DONE.
//   - gnt/rvalid arriving in the same cycle as the timeout wins over the timeout.
//  Store lanes, lane = addr[1:0]:
//   - SB: wdata = {4{b}}, be = 4'b0001<<lane
//   - SH: wdata = {2{h}}, be = 4'b0011<<lane
//   - SW: wdata = store data, be = 4'hF
//  Load extend:
//   - B/BU: byte at lane, sign/zero-extended
//   - H/HU: half at addr[1], sign/zero-extended
//   - W: word as-is
//  dmem_we_o = mem_write_m_i while req is high; be = 4'hF for loads.
//  Reset mid-access: FSM returns to IDLE; a late rvalid after reset is ignored.
// TESTING
//  1 LW addr=0x100, gnt same cycle, rvalid next with 0xDEADBEEF -> stall 1,1,0; read_data_o=0xDEADBEEF in DONE.
//  2 LB addr=0x103, rdata=0x80FF_FF_FF -> read_data_o=0xFFFFFF80; LBU -> 0x00000080; LHU addr=0x102 -> 0x000080FF.
//  3 SB addr=0x201, data=0x12345678, gnt delayed 3 cycles -> req held 4 cycles, be=0010, wdata=0x78787878; stall drops in DONE.
//  4 LW addr=0x102 -> no req, fault_o 1-cycle pulse, stall_o=0, read_data_o=0.
//  5 TIMEOUT_CYCLES=4, LW, never rvalid -> fault_o after 4 WAIT/REQ cycles, read_data_o=0, then DONE->IDLE.
//  6 rst asserted in WAIT, rvalid next cycle after release -> FSM IDLE, read_data_o=0, no stall.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit on a req/gnt/rvalid data bus
//
// Purpose: issues loads/stores from the MEM stage, steers store bytes onto
// lanes, aligns and sign/zero-extends load data, and holds the pipeline while
// an access is in flight. Illegal accesses and bus timeouts raise a one-cycle
// fault pulse and leave read_data_o at zero.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   valid_m_i                MEM-stage instruction valid
//   mem_read_m_i/_write_m_i  load / store select
//   funct3_m_i               RV32I width/sign code
//   addr_m_i, store_data_m_i effective address, store source value
//   dmem_*_o                 bus request: req, we, word addr, byte enables, wdata
//   dmem_gnt_i/rvalid_i/rdata_i  bus grant and read response
//   read_data_o              registered, extended load result
//   stall_o                  hold IF..MEM, MEM/WB must not capture
//   fault_o                  one-cycle pulse on illegal access or timeout
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_m_i,
  input  logic        mem_read_m_i,
  input  logic        mem_write_m_i,
  input  logic [2:0]  funct3_m_i,
  input  logic [31:0] addr_m_i,
  input  logic [31:0] store_data_m_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] read_data_o,
  output logic        stall_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_inc;
  logic [31:0] read_data_q;
  logic        fault_q;

  logic acc, both_rw, bad_f3, misalign, illegal, legal;
  logic req, stall, rd_load, rd_clear, fault_set;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Legality of the instruction currently sitting in MEM.
  always_comb begin
    acc     = valid_m_i & (mem_read_m_i ^ mem_write_m_i);
    both_rw = valid_m_i & mem_read_m_i & mem_write_m_i;
    if (mem_read_m_i) bad_f3 = (funct3_m_i == 3'd3) || (funct3_m_i[2:1] == 2'b11);
    else              bad_f3 = (funct3_m_i > 3'd2);
    case (funct3_m_i[1:0])
      2'd1:    misalign = addr_m_i[0];
      2'd2:    misalign = |addr_m_i[1:0];
      default: misalign = 1'b0;
    endcase
    illegal = both_rw | (acc & (bad_f3 | misalign));
    legal   = acc & ~(bad_f3 | misalign);
  end

  // Store lane steering: data is replicated so every enabled lane sees it.
  always_comb begin
    case (funct3_m_i[1:0])
      2'd0: begin
        st_be    = 4'b0001 << addr_m_i[1:0];
        st_wdata = {4{store_data_m_i[7:0]}};
      end
      2'd1: begin
        st_be    = 4'b0011 << addr_m_i[1:0];
        st_wdata = {2{store_data_m_i[15:0]}};
      end
      default: begin
        st_be    = 4'hF;
        st_wdata = store_data_m_i;
      end
    endcase
  end

  // Load alignment and extension; address/funct3 are frozen by the stall.
  always_comb begin
    ld_byte = dmem_rdata_i[{addr_m_i[1:0], 3'b000} +: 8];
    ld_half = dmem_rdata_i[{addr_m_i[1], 4'b0000} +: 16];
    case (funct3_m_i)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_ext = {24'h0, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd5:    ld_ext = {16'h0, ld_half};
      default: ld_ext = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cnt_inc   = {1'b0, cnt_q} + 17'd1;
    req       = 1'b0;
    stall     = 1'b0;
    rd_load   = 1'b0;
    rd_clear  = 1'b0;
    fault_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (legal) begin
          req   = 1'b1;
          stall = 1'b1;
          if (dmem_gnt_i) state_d = mem_read_m_i ? S_WAIT : S_DONE;
          else            state_d = S_REQ;
        end else if (illegal) begin
          rd_clear  = 1'b1;
          fault_set = 1'b1;
        end
      end
      S_REQ: begin
        req   = 1'b1;
        stall = 1'b1;
        cnt_d = cnt_inc[15:0];
        // A grant in the timeout cycle still completes the handshake.
        if (dmem_gnt_i) begin
          state_d = mem_read_m_i ? S_WAIT : S_DONE;
        end else if (cnt_inc >= TIMEOUT_LIM) begin
          rd_clear  = 1'b1;
          fault_set = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_inc[15:0];
        if (dmem_rvalid_i) begin
          rd_load = 1'b1;
          state_d = S_DONE;
        end else if (cnt_inc >= TIMEOUT_LIM) begin
          rd_clear  = 1'b1;
          fault_set = 1'b1;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      read_data_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_set;
      if (rd_load)       read_data_q <= ld_ext;
      else if (rd_clear) read_data_q <= '0;
    end
  end

  // Reset forces the bus quiet immediately, even with a legal access in MEM.
  assign dmem_req_o   = ~rst & req;
  assign dmem_we_o    = dmem_req_o & mem_write_m_i;
  assign dmem_addr_o  = dmem_req_o ? {addr_m_i[31:2], 2'b00} : 32'h0;
  assign dmem_be_o    = dmem_req_o ? (mem_write_m_i ? st_be : 4'hF) : 4'h0;
  assign dmem_wdata_o = dmem_we_o ? st_wdata : 32'h0;
  assign stall_o      = ~rst & stall;
  assign read_data_o  = read_data_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_m_i = 1'b0, mem_read_m_i = 1'b0, mem_write_m_i = 1'b0;
  logic [2:0]  funct3_m_i = 3'd0;
  logic [31:0] addr_m_i = 32'h0, store_data_m_i = 32'h0;
  logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = 32'h0;
  logic        dmem_req_o, dmem_we_o, stall_o, fault_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, read_data_o;
  logic [3:0]  dmem_be_o;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_rd = 32'h0;
  logic [2:0]  load_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .valid_m_i(valid_m_i), .mem_read_m_i(mem_read_m_i), .mem_write_m_i(mem_write_m_i),
    .funct3_m_i(funct3_m_i), .addr_m_i(addr_m_i), .store_data_m_i(store_data_m_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .read_data_o(read_data_o), .stall_o(stall_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic model_fault(input logic v, input logic r, input logic w,
                                       input logic [2:0] f, input logic [31:0] a);
    int size;
    if (!v) return 1'b0;
    if (r && w) return 1'b1;
    if (!r && !w) return 1'b0;
    if (r && !(f inside {0, 1, 2, 4, 5})) return 1'b1;
    if (w && f > 2) return 1'b1;
    size = 1 << (f % 4);
    return (a % size) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic w, input logic [2:0] f, input logic [31:0] a);
    int size;
    if (!w) return 4'hF;
    size = 1 << (f % 4);
    return 4'(((1 << size) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f, input logic [31:0] d);
    case (f % 4)
      0:       return d[7:0] * 32'h01010101;
      1:       return d[15:0] * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] rdata);
    longint x;
    x = rdata >> (8 * (a % 4));
    case (f)
      3'd0:    begin x = x % 256;   if (x >= 128)   x = x - 256;   end
      3'd4:    x = x % 256;
      3'd1:    begin x = x % 65536; if (x >= 32768) x = x - 65536; end
      3'd5:    x = x % 65536;
      default: x = rdata;
    endcase
    return 32'(x);
  endfunction

  task automatic bubble();
    valid_m_i = 1'b0; mem_read_m_i = 1'b0; mem_write_m_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
  endtask

  // One MEM-stage instruction with a bus that grants after gd cycles and
  // returns read data rdly cycles after the first WAIT cycle.
  task automatic run_access(input logic v, input logic r, input logic w, input logic [2:0] f,
                            input logic [31:0] a, input logic [31:0] d,
                            input int gd, input int rdly, input logic [31:0] rdat);
    logic flt, legal;
    flt   = model_fault(v, r, w, f, a);
    legal = v && (r != w) && !flt;
    @(negedge clk);
    valid_m_i = v; mem_read_m_i = r; mem_write_m_i = w; funct3_m_i = f;
    addr_m_i = a; store_data_m_i = d;
    dmem_gnt_i = legal ? (gd == 0) : 1'($urandom);
    dmem_rvalid_i = !legal;
    dmem_rdata_i = $urandom;
    #1;
    if (!legal) begin
      total++; if (dmem_req_o !== 1'b0) begin bad++; $display("FAIL nolegal_req: got %b want 0 a=%h f=%0d", dmem_req_o, a, f); end
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL nolegal_stall: got %b want 0 a=%h f=%0d", stall_o, a, f); end
      @(negedge clk);
      bubble();
      if (flt) exp_rd = 32'h0;
      #1;
      total++; if (fault_o !== flt) begin bad++; $display("FAIL nolegal_fault: got %b want %b a=%h f=%0d", fault_o, flt, a, f); end
      total++; if (read_data_o !== exp_rd) begin bad++; $display("FAIL nolegal_rdata: got %h want %h", read_data_o, exp_rd); end
      return;
    end
    for (int i = 0; i <= gd; i++) begin
      if (i > 0) begin
        @(negedge clk);
        dmem_gnt_i = (i == gd);
        #1;
      end
      total++; if (dmem_req_o !== 1'b1) begin bad++; $display("FAIL req_held: got %b want 1 cyc=%0d", dmem_req_o, i); end
      total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL req_stall: got %b want 1 cyc=%0d", stall_o, i); end
      total++; if (dmem_we_o !== w) begin bad++; $display("FAIL req_we: got %b want %b", dmem_we_o, w); end
      total++; if (dmem_addr_o !== (a & 32'hFFFF_FFFC)) begin bad++; $display("FAIL req_addr: got %h want %h", dmem_addr_o, a & 32'hFFFF_FFFC); end
      total++; if (dmem_be_o !== model_be(w, f, a)) begin bad++; $display("FAIL req_be: got %b want %b a=%h f=%0d", dmem_be_o, model_be(w, f, a), a, f); end
      if (w) begin
        total++; if (dmem_wdata_o !== model_wdata(f, d)) begin bad++; $display("FAIL req_wdata: got %h want %h", dmem_wdata_o, model_wdata(f, d)); end
      end
    end
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    if (r) begin
      for (int i = 0; i <= rdly; i++) begin
        dmem_rvalid_i = (i == rdly);
        dmem_rdata_i  = (i == rdly) ? rdat : $urandom;
        #1;
        total++; if (dmem_req_o !== 1'b0) begin bad++; $display("FAIL wait_req: got %b want 0", dmem_req_o); end
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL wait_stall: got %b want 1", stall_o); end
        @(negedge clk);
      end
      dmem_rvalid_i = 1'b0;
      exp_rd = model_load(f, a, rdat);
    end
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL done_stall: got %b want 0", stall_o); end
    total++; if (dmem_req_o !== 1'b0) begin bad++; $display("FAIL done_req: got %b want 0", dmem_req_o); end
    total++; if (fault_o !== 1'b0) begin bad++; $display("FAIL done_fault: got %b want 0", fault_o); end
    total++; if (read_data_o !== exp_rd) begin bad++; $display("FAIL done_rdata: got %h want %h a=%h f=%0d", read_data_o, exp_rd, a, f); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    valid_m_i = 1'b1; mem_read_m_i = 1'b1; funct3_m_i = 3'd2; addr_m_i = 32'h100; dmem_gnt_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    total++; if (dmem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", dmem_req_o); end
    total++; if (dmem_be_o !== 4'h0) begin bad++; $display("FAIL reset_be: got %b want 0000", dmem_be_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    total++; if (read_data_o !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", read_data_o); end
    total++; if (fault_o !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", fault_o); end
    bubble();
    rst = 1'b0;
  endtask

  task automatic test_lw();
    run_access(1, 1, 0, 3'd2, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    total++; if (read_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_value: got %h want deadbeef", read_data_o); end
  endtask

  task automatic test_loads();
    run_access(1, 1, 0, 3'd0, 32'h103, 32'h0, 0, 0, 32'h80FFFFFF);
    total++; if (read_data_o !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_value: got %h want ffffff80", read_data_o); end
    run_access(1, 1, 0, 3'd4, 32'h103, 32'h0, 0, 0, 32'h80FFFFFF);
    total++; if (read_data_o !== 32'h00000080) begin bad++; $display("FAIL lbu_value: got %h want 00000080", read_data_o); end
    run_access(1, 1, 0, 3'd5, 32'h102, 32'h0, 0, 0, 32'h80FFFFFF);
    total++; if (read_data_o !== 32'h000080FF) begin bad++; $display("FAIL lhu_value: got %h want 000080ff", read_data_o); end
  endtask

  task automatic test_sb_delayed();
    run_access(1, 0, 1, 3'd0, 32'h201, 32'h12345678, 3, 0, 32'h0);
  endtask

  task automatic test_illegal();
    run_access(1, 1, 0, 3'd2, 32'h102, 32'h0, 0, 0, 32'h0);
    @(negedge clk); #1;
    total++; if (fault_o !== 1'b0) begin bad++; $display("FAIL fault_pulse_width: got %b want 0", fault_o); end
    run_access(1, 1, 1, 3'd2, 32'h100, 32'h0, 0, 0, 32'h0);
    run_access(1, 0, 1, 3'd3, 32'h100, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic test_timeout(input logic gnt_first);
    run_access(1, 1, 0, 3'd2, 32'h300, 32'h0, 0, 0, 32'hA5A50001);
    @(negedge clk);
    valid_m_i = 1'b1; mem_read_m_i = 1'b1; mem_write_m_i = 1'b0; funct3_m_i = 3'd2; addr_m_i = 32'h304;
    dmem_gnt_i = gnt_first; dmem_rvalid_i = 1'b0;
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL to_idle_stall: got %b want 1", stall_o); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dmem_gnt_i = 1'b0;
      #1;
      total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL to_stall: got %b want 1 cyc=%0d", stall_o, i); end
      total++; if (fault_o !== 1'b0) begin bad++; $display("FAIL to_early_fault: got %b want 0 cyc=%0d", fault_o, i); end
      total++; if (dmem_req_o !== !gnt_first) begin bad++; $display("FAIL to_req: got %b want %b", dmem_req_o, !gnt_first); end
    end
    @(negedge clk); #1;
    exp_rd = 32'h0;
    total++; if (fault_o !== 1'b1) begin bad++; $display("FAIL to_fault: got %b want 1", fault_o); end
    total++; if (read_data_o !== 32'h0) begin bad++; $display("FAIL to_rdata: got %h want 0", read_data_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL to_done_stall: got %b want 0", stall_o); end
    @(negedge clk);
    bubble();
    #1;
    total++; if (fault_o !== 1'b0) begin bad++; $display("FAIL to_pulse_width: got %b want 0", fault_o); end
  endtask

  task automatic test_race();
    run_access(1, 1, 0, 3'd2, 32'h400, 32'h0, 0, 3, 32'h0BADF00D);
    run_access(1, 1, 0, 3'd1, 32'h406, 32'h0, 3, 0, 32'h8001_7FFF);
    run_access(1, 0, 1, 3'd2, 32'h408, 32'hCAFEF00D, 4, 0, 32'h0);
  endtask

  task automatic test_reset_mid();
    run_access(1, 1, 0, 3'd2, 32'h104, 32'h0, 0, 0, 32'h12345678);
    @(negedge clk);
    valid_m_i = 1'b1; mem_read_m_i = 1'b1; mem_write_m_i = 1'b0; funct3_m_i = 3'd2; addr_m_i = 32'h108;
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL rm_wait_stall: got %b want 1", stall_o); end
    rst = 1'b1;
    #1;
    total++; if (dmem_req_o !== 1'b0) begin bad++; $display("FAIL rm_req: got %b want 0", dmem_req_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rm_stall: got %b want 0", stall_o); end
    total++; if (read_data_o !== 32'h0) begin bad++; $display("FAIL rm_rdata: got %h want 0", read_data_o); end
    @(negedge clk);
    rst = 1'b0;
    bubble();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rm_late_stall: got %b want 0", stall_o); end
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    #1;
    exp_rd = 32'h0;
    total++; if (read_data_o !== 32'h0) begin bad++; $display("FAIL rm_late_rdata: got %h want 0", read_data_o); end
    total++; if (fault_o !== 1'b0) begin bad++; $display("FAIL rm_late_fault: got %b want 0", fault_o); end
  endtask

  task automatic test_random();
    logic v, r, w;
    logic [2:0] f;
    logic [31:0] a, d;
    int kind, gd, rdly;
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 7);
      v = 1'b1; r = 1'b0; w = 1'b0;
      f = 3'($urandom); a = $urandom; d = $urandom;
      gd = $urandom_range(0, 2); rdly = $urandom_range(0, 1);
      case (kind)
        0, 1, 2: begin
          r = 1'b1; f = load_codes[$urandom_range(0, 4)];
          a = a & ~(32'((1 << (f % 4)) - 1));
        end
        3, 4: begin
          w = 1'b1; f = 3'($urandom_range(0, 2));
          a = a & ~(32'((1 << (f % 4)) - 1));
        end
        5: v = 1'($urandom);
        default: begin v = 1'($urandom); r = 1'($urandom); w = 1'($urandom); end
      endcase
      run_access(v, r, w, f, a, d, gd, rdly, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_loads();
    test_sb_delayed();
    test_illegal();
    test_timeout(1'b1);
    test_timeout(1'b0);
    test_race();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
